ifetch_unit: RTL and testbench

In-order instruction fetch stage between the program counter and decode. Takes fetch addresses from the PC stage with a valid/ready handshake and issues them to instruction memory over a request/grant/response interface. Responses are held in a DEPTH-entry in-order buffer, so memory latency and decode backpressure never reorder or lose instructions. A redirect flush discards every queued or in-flight fetch.

---
 rtl/ifetch_if.sv | 33 +++
 rtl/ifetch_unit.sv | 113 +++++++++++
 tb/tb_ifetch_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// ifetch_if: bundles the three handshakes around the fetch stage.
//   PC side     : pc_i, pc_valid -> ; <- pc_ready ; flush (redirect pulse)
//   Memory side : <- imem_req, imem_addr ; imem_gnt, imem_rvalid, imem_rdata ->
//   Decode side : <- instr_valid, instr, instr_pc ; instr_ready ->
// slave is the fetch unit; master is whatever surrounds it.
interface ifetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic [ADDR_WIDTH-1:0] pc_i;
  logic                  pc_valid;
  logic                  pc_ready;
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport slave (
    input  flush, pc_i, pc_valid, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output pc_ready, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport master (
    output flush, pc_i, pc_valid, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  pc_ready, imem_req, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: in-order instruction fetch stage.
// Accepts fetch addresses from the PC stage, issues them to instruction
// memory, and holds responses in a DEPTH-entry circular buffer so that
// memory latency and decode backpressure never reorder or lose
// instructions. A flush kills everything queued; responses still owed by
// memory for killed fetches are counted in r_drop_cnt and discarded.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      ifetch_if.slave (PC, memory and decode handshakes, flush)
module ifetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic    clk,
  input  logic    reset_n,
  ifetch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_filled;
  logic [PW-1:0]         r_alloc_ptr;
  logic [PW-1:0]         r_fill_ptr;
  logic [PW-1:0]         r_head_ptr;
  logic [CW-1:0]         r_alloc_cnt;
  // Allocated entries still waiting for their response.
  logic [CW-1:0]         r_pend_cnt;
  // Responses still owed for fetches killed by a flush.
  logic [CW-1:0]         r_drop_cnt;

  logic [CW:0] w_credit_used;
  logic        w_space;
  logic        w_req;
  logic        w_accept;
  logic        w_resp_drop;
  logic        w_resp_fill;
  logic        w_resp_live;
  logic        w_valid;
  logic        w_pop;

  // Credit is taken from registered counts only, so a pop from a full buffer
  // frees a slot one cycle later and imem_req never depends on imem_gnt.
  assign w_credit_used = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt};
  assign w_space       = (w_credit_used < (CW+1)'(DEPTH));

  assign w_req    = bus.pc_valid & w_space & ~bus.flush;
  assign w_accept = w_req & bus.imem_gnt;

  // A response with nothing owed (no drop, no pending) is ignored.
  assign w_resp_drop = bus.imem_rvalid & (r_drop_cnt != '0);
  assign w_resp_fill = bus.imem_rvalid & (r_drop_cnt == '0) & (r_pend_cnt != '0);
  assign w_resp_live = w_resp_drop | w_resp_fill;

  assign w_valid = r_filled[r_head_ptr] & (r_alloc_cnt != '0) & ~bus.flush;
  assign w_pop   = w_valid & bus.instr_ready;

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = {bus.pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign bus.pc_ready    = w_accept;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = r_data[r_head_ptr];
  assign bus.instr_pc    = r_pc[r_head_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_data[i] <= '0;
      end
      r_filled    <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_alloc_cnt <= '0;
      r_pend_cnt  <= '0;
      r_drop_cnt  <= '0;
    end else if (bus.flush) begin
      // Every unfilled entry still has a response on its way; a response
      // arriving right now settles one of those debts already.
      r_drop_cnt  <= r_drop_cnt + r_pend_cnt - CW'(w_resp_live);
      r_filled    <= '0;
      r_alloc_cnt <= '0;
      r_pend_cnt  <= '0;
      r_fill_ptr  <= r_alloc_ptr;
      r_head_ptr  <= r_alloc_ptr;
    end else begin
      // Index collisions between pop, fill and accept cannot occur: each
      // would require the buffer to be simultaneously full and empty of
      // the relevant kind of entry.
      if (w_pop) begin
        r_filled[r_head_ptr] <= 1'b0;
        r_head_ptr           <= r_head_ptr + PW'(1);
      end
      if (w_resp_fill) begin
        r_data[r_fill_ptr]   <= bus.imem_rdata;
        r_filled[r_fill_ptr] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + PW'(1);
      end
      if (w_accept) begin
        r_pc[r_alloc_ptr]     <= bus.pc_i;
        r_filled[r_alloc_ptr] <= 1'b0;
        r_alloc_ptr           <= r_alloc_ptr + PW'(1);
      end
      r_alloc_cnt <= r_alloc_cnt + CW'(w_accept) - CW'(w_pop);
      r_pend_cnt  <= r_pend_cnt + CW'(w_accept) - CW'(w_resp_fill);
      r_drop_cnt  <= r_drop_cnt - CW'(w_resp_drop);
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit. Memory returns
// addr ^ 32'hA5A5A5A5; responses are driven per cycle by the tasks.
module tb_ifetch_unit;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] XORK = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ifetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  ifetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int out_cnt  = 0;
  int stray_cnt = 0;
  logic [AW-1:0] gq[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] next_pc = '0;

  // Record what happens on the coming edge, then advance one cycle.
  task automatic tick();
    if (bus.imem_rvalid) begin
      if (out_cnt == 0) stray_cnt++;
      else out_cnt--;
    end
    if (bus.imem_req && bus.imem_gnt) begin
      out_cnt++;
      gq.push_back(bus.imem_addr);
      exp_q.push_back(bus.pc_i);
      next_pc = bus.pc_i + 32'd4;
    end
    if (bus.flush) exp_q.delete();
    else if (bus.instr_valid && bus.instr_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input bit en);
    logic [AW-1:0] a;
    if (en && gq.size() > 0) begin
      a = gq.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = a ^ XORK;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
  endtask

  task automatic test_reset();
    bus.flush = 0; bus.pc_i = '0; bus.pc_valid = 0; bus.imem_gnt = 0;
    bus.imem_rvalid = 0; bus.imem_rdata = '0; bus.instr_ready = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pc_ready: got %b want 0", bus.pc_ready); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_imem_addr: got %h want 0", bus.imem_addr); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.instr); end
    n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] ep;
    bus.instr_ready = 1; bus.imem_gnt = 1; bus.flush = 0;
    for (int c = 0; c < 12; c++) begin
      bus.pc_valid = (c < 10);
      bus.pc_i = 32'(c * 4);
      respond(1);
      #1;
      if (c < 10) begin
        n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL stream_pc_ready c=%0d: got %b want 1", c, bus.pc_ready); end
      end
      n_checks++; if (bus.instr_valid !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid c=%0d: got %b want %b", c, bus.instr_valid, (c >= 2)); end
      if (c >= 2) begin
        ep = 32'((c - 2) * 4);
        n_checks++; if (bus.instr_pc !== ep) begin n_fail++; $display("FAIL stream_pc c=%0d: got %h want %h", c, bus.instr_pc, ep); end
        n_checks++; if (bus.instr !== (ep ^ XORK)) begin n_fail++; $display("FAIL stream_instr c=%0d: got %h want %h", c, bus.instr, ep ^ XORK); end
      end
      tick();
    end
    bus.pc_valid = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ep;
    bus.instr_ready = 0; bus.pc_valid = 1; bus.imem_gnt = 1; next_pc = '0;
    for (int c = 0; c < 8; c++) begin
      bus.pc_i = next_pc;
      respond(1);
      #1;
      n_checks++; if (bus.imem_req !== (c < 4)) begin n_fail++; $display("FAIL bp_req c=%0d: got %b want %b", c, bus.imem_req, (c < 4)); end
      tick();
    end
    bus.instr_ready = 1;
    for (int d = 0; d < 4; d++) begin
      bus.pc_i = next_pc;
      respond(1);
      #1;
      ep = 32'(d * 4);
      n_checks++; if (bus.imem_req !== (d >= 1)) begin n_fail++; $display("FAIL bp_resume_req d=%0d: got %b want %b", d, bus.imem_req, (d >= 1)); end
      n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid d=%0d: got %b want 1", d, bus.instr_valid); end
      n_checks++; if (bus.instr_pc !== ep) begin n_fail++; $display("FAIL bp_drain_pc d=%0d: got %h want %h", d, bus.instr_pc, ep); end
      n_checks++; if (bus.instr !== (ep ^ XORK)) begin n_fail++; $display("FAIL bp_drain_instr d=%0d: got %h want %h", d, bus.instr, ep ^ XORK); end
      tick();
    end
    bus.pc_valid = 0;
    for (int k = 0; k < 20 && (exp_q.size() > 0 || gq.size() > 0); k++) begin
      respond(1);
      #1;
      if (bus.instr_valid) begin
        ep = exp_q[0];
        n_checks++; if (bus.instr_pc !== ep) begin n_fail++; $display("FAIL bp_tail_pc: got %h want %h", bus.instr_pc, ep); end
        n_checks++; if (bus.instr !== (ep ^ XORK)) begin n_fail++; $display("FAIL bp_tail_instr: got %h want %h", bus.instr, ep ^ XORK); end
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain_done: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_flush_discard();
    bus.instr_ready = 1; bus.imem_gnt = 1; bus.flush = 0;
    bus.pc_valid = 1; bus.pc_i = 32'h10; respond(0); #1;
    n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL fd_grant0: got %b want 1", bus.pc_ready); end
    tick();
    bus.pc_i = 32'h14; respond(0); #1;
    n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL fd_grant1: got %b want 1", bus.pc_ready); end
    tick();
    bus.flush = 1; bus.pc_i = 32'h18; respond(0); #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL fd_flush_req: got %b want 0", bus.imem_req); end
    n_checks++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL fd_flush_ready: got %b want 0", bus.pc_ready); end
    tick();
    bus.flush = 0; bus.pc_i = 32'h100; respond(0); #1;
    n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL fd_regrant: got %b want 1", bus.pc_ready); end
    n_checks++; if (dut.r_drop_cnt !== 3'd2) begin n_fail++; $display("FAIL fd_drop_cnt: got %0d want 2", dut.r_drop_cnt); end
    tick();
    bus.pc_valid = 0;
    for (int c = 0; c < 3; c++) begin
      respond(1); #1;
      n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL fd_quiet c=%0d: got %b want 0", c, bus.instr_valid); end
      tick();
    end
    respond(0); #1;
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL fd_valid: got %b want 1", bus.instr_valid); end
    n_checks++; if (bus.instr_pc !== 32'h100) begin n_fail++; $display("FAIL fd_pc: got %h want 100", bus.instr_pc); end
    n_checks++; if (bus.instr !== (32'h100 ^ XORK)) begin n_fail++; $display("FAIL fd_instr: got %h want %h", bus.instr, 32'h100 ^ XORK); end
    tick();
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL fd_empty: got %b want 0", bus.instr_valid); end
  endtask

  task automatic test_flush_rvalid();
    bus.instr_ready = 1; bus.imem_gnt = 1; bus.flush = 0;
    bus.pc_valid = 1; bus.pc_i = 32'h20; respond(0); #1; tick();
    bus.pc_i = 32'h24; respond(0); #1; tick();
    bus.pc_valid = 0; bus.flush = 1; respond(1); #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL fr_flush_valid: got %b want 0", bus.instr_valid); end
    tick();
    bus.flush = 0;
    n_checks++; if (dut.r_drop_cnt !== 3'd1) begin n_fail++; $display("FAIL fr_drop_cnt: got %0d want 1", dut.r_drop_cnt); end
    bus.pc_valid = 1; bus.pc_i = 32'h28; respond(1); #1;
    n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL fr_regrant: got %b want 1", bus.pc_ready); end
    tick();
    bus.pc_valid = 0; respond(1); #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL fr_quiet: got %b want 0", bus.instr_valid); end
    tick();
    respond(0); #1;
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL fr_valid: got %b want 1", bus.instr_valid); end
    n_checks++; if (bus.instr_pc !== 32'h28) begin n_fail++; $display("FAIL fr_pc: got %h want 28", bus.instr_pc); end
    n_checks++; if (bus.instr !== (32'h28 ^ XORK)) begin n_fail++; $display("FAIL fr_instr: got %h want %h", bus.instr, 32'h28 ^ XORK); end
    tick();
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL fr_empty: got %b want 0", bus.instr_valid); end
  endtask

  task automatic test_gnt_stall();
    bus.instr_ready = 1; bus.imem_gnt = 0; bus.flush = 0;
    bus.pc_valid = 1; bus.pc_i = 32'h40;
    for (int s = 0; s < 3; s++) begin
      respond(0); #1;
      n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL gs_req s=%0d: got %b want 1", s, bus.imem_req); end
      n_checks++; if (bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL gs_addr s=%0d: got %h want 40", s, bus.imem_addr); end
      n_checks++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL gs_ready s=%0d: got %b want 0", s, bus.pc_ready); end
      tick();
    end
    bus.imem_gnt = 1; #1;
    n_checks++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL gs_grant: got %b want 1", bus.pc_ready); end
    tick();
    bus.pc_valid = 0; respond(1); #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL gs_early: got %b want 0", bus.instr_valid); end
    tick();
    respond(0); #1;
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL gs_valid: got %b want 1", bus.instr_valid); end
    n_checks++; if (bus.instr_pc !== 32'h40) begin n_fail++; $display("FAIL gs_pc: got %h want 40", bus.instr_pc); end
    tick();
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL gs_single_alloc: got %b want 0", bus.instr_valid); end
    n_checks++; if (dut.r_alloc_cnt !== 3'd0) begin n_fail++; $display("FAIL gs_alloc_cnt: got %0d want 0", dut.r_alloc_cnt); end
  endtask

  task automatic test_reset_mid();
    bus.instr_ready = 0; bus.imem_gnt = 1; bus.flush = 0; bus.pc_valid = 1;
    for (int c = 0; c < 3; c++) begin
      bus.pc_i = 32'(c * 4);
      respond(1); #1;
      tick();
    end
    bus.pc_valid = 0; bus.pc_i = '0; respond(0); #1;
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_valid: got %b want 1", bus.instr_valid); end
    reset_n = 0;
    #1;
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_instr_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rm_instr: got %h want 0", bus.instr); end
    n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rm_instr_pc: got %h want 0", bus.instr_pc); end
    n_checks++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pc_ready: got %b want 0", bus.pc_ready); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_imem_req: got %b want 0", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_imem_addr: got %h want 0", bus.imem_addr); end
    n_checks++; if (dut.r_alloc_cnt !== 3'd0) begin n_fail++; $display("FAIL rm_alloc_cnt: got %0d want 0", dut.r_alloc_cnt); end
    gq.delete(); exp_q.delete(); out_cnt = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    // Response for the fetch of 0x8 that was in flight across the reset.
    bus.imem_rvalid = 1; bus.imem_rdata = 32'h8 ^ XORK;
    #1;
    tick();
    respond(0); #1;
    n_checks++; if (stray_cnt !== 1) begin n_fail++; $display("FAIL rm_stray_flag: got %0d want 1", stray_cnt); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stray_ignored: got %b want 0", bus.instr_valid); end
    n_checks++; if (dut.r_pend_cnt !== 3'd0) begin n_fail++; $display("FAIL rm_pend_cnt: got %0d want 0", dut.r_pend_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_discard();
    test_flush_rvalid();
    test_gnt_stall();
    n_checks++; if (stray_cnt !== 0) begin n_fail++; $display("FAIL no_stray_before_reset: got %0d want 0", stray_cnt); end
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
